line_fill_axi_rd: RTL and testbench

- Cache-miss line fill engine between the AXI4 read channel and the cache data array.
- On a fill request it issues one INCR read burst for a full cache line and assembles the beats into a line buffer.
- It presents the assembled line as the data-array memory-side line input and signals completion to the cache controller, which then drives the miss/replace command.

---
 rtl/line_fill_axi_rd_if.sv | 35 +++
 rtl/line_fill_axi_rd.sv | 137 +++++++++++++
 tb/tb_line_fill_axi_rd.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/line_fill_axi_rd_if.sv
// AXI4 read-address and read-data channels used by the line fill engine.
// master drives AR and rready; slave drives arready and the R beat.
interface line_fill_axi_rd_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_SIZE  = 32,
    parameter int ID_WIDTH   = 4
) ();
    logic                  m_arvalid;
    logic                  m_arready;
    logic [ADDR_WIDTH-1:0] m_araddr;
    logic [7:0]            m_arlen;
    logic [2:0]            m_arsize;
    logic [1:0]            m_arburst;
    logic [ID_WIDTH-1:0]   m_arid;
    logic                  m_rvalid;
    logic                  m_rready;
    logic [DATA_SIZE-1:0]  m_rdata;
    logic [1:0]            m_rresp;
    logic                  m_rlast;
    logic [ID_WIDTH-1:0]   m_rid;

    modport master (
        output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid,
        input  m_arready,
        input  m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        output m_rready
    );

    modport slave (
        input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arid,
        output m_arready,
        output m_rvalid, m_rdata, m_rresp, m_rlast, m_rid,
        input  m_rready
    );
endinterface

// File: rtl/line_fill_axi_rd.sv
// Cache line fill engine: one AXI4 INCR read burst per miss into a line buffer.
// Define LINE_FILL_LAT_CNT_EN to add the fill_lat latency output.
module line_fill_axi_rd #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  fill_req,
    input  logic [ADDR_WIDTH-1:0]                 fill_addr,
    output logic                                  fill_busy,
    output logic                                  fill_done,
    output logic                                  fill_err,
    output logic [(1<<BLOCK_SIZE)*DATA_SIZE-1:0]  line_out,
`ifdef LINE_FILL_LAT_CNT_EN
    output logic [15:0]                           fill_lat,
`endif
    line_fill_axi_rd_if.master                    axi
);
    localparam int BLOCKS = 1 << BLOCK_SIZE;
    localparam int OFF    = $clog2(DATA_SIZE / 8) + BLOCK_SIZE;

    localparam logic [BLOCK_SIZE:0]   LAST_BEAT = (BLOCK_SIZE + 1)'(BLOCKS - 1);
    localparam logic [ID_WIDTH-1:0]   ID        = ID_WIDTH'(AXI_ID);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFF;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]                   state;
    logic [BLOCK_SIZE:0]          beat_cnt;
    logic                         err_q;
    logic                         fill_err_q;
    logic [ADDR_WIDTH-1:0]        araddr_q;
    logic [BLOCKS*DATA_SIZE-1:0]  line_q;

    logic                  beat;
    logic                  is_last;
    logic                  beat_err;
    logic                  end_burst;
    logic                  accept;
    logic [BLOCK_SIZE-1:0] widx;

    assign accept  = (state == IDLE) && fill_req;
    assign beat    = (state == DATA) && axi.m_rvalid;
    assign is_last = (beat_cnt == LAST_BEAT);
    assign widx    = beat_cnt[BLOCK_SIZE-1:0];

    // rlast must coincide with the final counted beat, in either direction
    assign beat_err = (axi.m_rresp >= 2'b10)
                    | (axi.m_rid != ID)
                    | (axi.m_rlast != is_last);

    assign end_burst = beat && (axi.m_rlast || is_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            err_q      <= 1'b0;
            fill_err_q <= 1'b0;
            araddr_q   <= '0;
            line_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_req) begin
                        araddr_q   <= fill_addr & ADDR_MASK;
                        beat_cnt   <= '0;
                        err_q      <= 1'b0;
                        fill_err_q <= 1'b0;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (axi.m_arready) state <= DATA;
                end
                DATA: begin
                    if (beat) begin
                        line_q[widx*DATA_SIZE +: DATA_SIZE] <= axi.m_rdata;
                        beat_cnt <= beat_cnt + 1'b1;
                        err_q    <= err_q | beat_err;
                    end
                    if (end_burst) begin
                        fill_err_q <= err_q | beat_err;
                        state      <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign fill_busy = (state != IDLE);
    assign fill_done = (state == DONE);
    assign fill_err  = fill_err_q;
    assign line_out  = line_q;

    assign axi.m_arvalid = (state == ADDR);
    assign axi.m_araddr  = araddr_q;
    assign axi.m_arlen   = 8'(BLOCKS - 1);
    assign axi.m_arsize  = 3'($clog2(DATA_SIZE / 8));
    assign axi.m_arburst = 2'b01;
    assign axi.m_arid    = ID;
    assign axi.m_rready  = (state == DATA);

`ifdef LINE_FILL_LAT_CNT_EN
    logic [15:0] lat_cnt;
    logic [15:0] lat_inc;
    logic [15:0] fill_lat_q;

    assign lat_inc = (lat_cnt == 16'hFFFF) ? lat_cnt : lat_cnt + 16'd1;

    // lat_cnt holds the index of the current cycle counted from acceptance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt    <= '0;
            fill_lat_q <= '0;
        end else begin
            if (accept) begin
                lat_cnt <= 16'd1;
            end else if (state == ADDR || state == DATA) begin
                lat_cnt <= lat_inc;
            end
            if (end_burst) fill_lat_q <= lat_inc;
        end
    end

    assign fill_lat = fill_lat_q;
`endif
endmodule

// File: tb/tb_line_fill_axi_rd.sv
// Self-checking bench for line_fill_axi_rd with a beat scoreboard.
// Covers LINE_FILL_LAT_CNT_EN when that macro is defined.
module tb_line_fill_axi_rd;
    localparam int AW     = 32;
    localparam int DW     = 32;
    localparam int BS     = 6;
    localparam int IW     = 4;
    localparam int BLOCKS = 1 << BS;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fill_req = 1'b0;
    logic [AW-1:0]        fill_addr = '0;
    logic                 fill_busy;
    logic                 fill_done;
    logic                 fill_err;
    logic [BLOCKS*DW-1:0] line_out;
`ifdef LINE_FILL_LAT_CNT_EN
    logic [15:0]          fill_lat;
`endif

    always #5 clk = ~clk;

    line_fill_axi_rd_if #(.ADDR_WIDTH(AW), .DATA_SIZE(DW), .ID_WIDTH(IW)) axi ();

    line_fill_axi_rd #(
        .ADDR_WIDTH(AW), .DATA_SIZE(DW), .BLOCK_SIZE(BS),
        .ID_WIDTH(IW), .AXI_ID(0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .fill_req(fill_req),
        .fill_addr(fill_addr),
        .fill_busy(fill_busy),
        .fill_done(fill_done),
        .fill_err(fill_err),
        .line_out(line_out),
`ifdef LINE_FILL_LAT_CNT_EN
        .fill_lat(fill_lat),
`endif
        .axi(axi)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int done_cnt = 0;
    int acc_cyc = 0;

    logic [DW-1:0] model [BLOCKS];
    logic [DW-1:0] exp_q [$];
    logic          exp_err_q [$];

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (fill_done === 1'b1) done_cnt++;

    task automatic start_fill(input logic [AW-1:0] addr);
        @(negedge clk);
        n_cmp++;
        if (fill_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL start_idle: busy=%b required 0", fill_busy);
        end
        fill_req  = 1'b1;
        fill_addr = addr;
        acc_cyc   = cyc;
        @(negedge clk);
        fill_req  = 1'b0;
        fill_addr = $urandom;
    endtask

    task automatic addr_phase(input logic [AW-1:0] exp_addr, input int stall);
        for (int n = 0; n <= stall; n++) begin
            n_cmp++;
            if (axi.m_arvalid !== 1'b1 || axi.m_araddr !== exp_addr ||
                fill_busy !== 1'b1) begin
                n_bad++;
                $display("FAIL ar_hold: arvalid=%b araddr=%h busy=%b required 1 %h 1",
                         axi.m_arvalid, axi.m_araddr, fill_busy, exp_addr);
            end
            if (n == 0) begin
                n_cmp++;
                if (axi.m_arlen !== 8'd63 || axi.m_arsize !== 3'd2 ||
                    axi.m_arburst !== 2'b01 || axi.m_arid !== 4'd0) begin
                    n_bad++;
                    $display("FAIL ar_const: len=%0d size=%0d burst=%b id=%0d required 63 2 01 0",
                             axi.m_arlen, axi.m_arsize, axi.m_arburst, axi.m_arid);
                end
            end
            axi.m_arready = (n == stall);
            @(negedge clk);
        end
        axi.m_arready = 1'b0;
        n_cmp++;
        if (axi.m_arvalid !== 1'b0 || axi.m_rready !== 1'b1) begin
            n_bad++;
            $display("FAIL ar_handshake: arvalid=%b rready=%b required 0 1",
                     axi.m_arvalid, axi.m_rready);
        end
    endtask

    task automatic data_phase(input int base, input int n_beats, input int rlast_beat,
                              input int err_beat, input int id_beat, input bit gap);
        int   i = 0;
        int   k = 0;
        logic busy_ok = 1'b1;
        logic exp_err;
        exp_err = (rlast_beat != BLOCKS - 1);
        while (i < n_beats && k < 1000) begin
            if (fill_busy !== 1'b1 || axi.m_rready !== 1'b1) busy_ok = 1'b0;
            if (!gap || (k % 2) == 0) begin
                axi.m_rvalid = 1'b1;
                axi.m_rdata  = DW'(base + i);
                axi.m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
                axi.m_rlast  = (i == rlast_beat);
                axi.m_rid    = (i == id_beat) ? 4'd3 : 4'd0;
                model[i]     = DW'(base + i);
                if (i == err_beat || i == id_beat) exp_err = 1'b1;
                i++;
            end else begin
                axi.m_rvalid = 1'b0;
                axi.m_rdata  = $urandom;
            end
            @(negedge clk);
            k++;
        end
        axi.m_rvalid = 1'b0;
        axi.m_rlast  = 1'b0;
        axi.m_rresp  = 2'b00;
        axi.m_rid    = 4'd0;
        n_cmp++;
        if (!busy_ok || k >= 1000) begin
            n_bad++;
            $display("FAIL data_busy_rready: ok=%b cycles=%0d required 1 <1000", busy_ok, k);
        end
        for (int w = 0; w < BLOCKS; w++) exp_q.push_back(model[w]);
        exp_err_q.push_back(exp_err);
    endtask

    task automatic finish_fill(input int exp_lat);
        logic [DW-1:0] ew;
        logic          ee;
        n_cmp++;
        if (fill_done !== 1'b1) begin
            n_bad++;
            $display("FAIL done_pulse: fill_done=%b required 1", fill_done);
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (cyc - acc_cyc != exp_lat) begin
                n_bad++;
                $display("FAIL done_latency: got %0d required %0d", cyc - acc_cyc, exp_lat);
            end
        end
        if (exp_q.size() < BLOCKS || exp_err_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_empty: size=%0d required %0d", exp_q.size(), BLOCKS);
        end else begin
            for (int w = 0; w < BLOCKS; w++) begin
                ew = exp_q.pop_front();
                n_cmp++;
                if (line_out[w*DW +: DW] !== ew) begin
                    n_bad++;
                    $display("FAIL line_word[%0d]: got %h required %h",
                             w, line_out[w*DW +: DW], ew);
                end
            end
            ee = exp_err_q.pop_front();
            n_cmp++;
            if (fill_err !== ee) begin
                n_bad++;
                $display("FAIL fill_err: got %b required %b", fill_err, ee);
            end
        end
    endtask

    task automatic do_fill(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                           input int stall, input int base, input int n_beats,
                           input int rlast_beat, input int err_beat, input int id_beat,
                           input bit gap, input int exp_lat);
        logic held_err;
        start_fill(addr);
        addr_phase(exp_addr, stall);
        data_phase(base, n_beats, rlast_beat, err_beat, id_beat, gap);
        finish_fill(exp_lat);
        held_err = fill_err;
        @(negedge clk);
        n_cmp++;
        if (fill_done !== 1'b0 || fill_busy !== 1'b0 || fill_err !== held_err) begin
            n_bad++;
            $display("FAIL post_done_idle: done=%b busy=%b err=%b required 0 0 %b",
                     fill_done, fill_busy, fill_err, held_err);
        end
    endtask

    task automatic test_reset;
        axi.m_arready = 1'b0;
        axi.m_rvalid  = 1'b0;
        axi.m_rdata   = '0;
        axi.m_rresp   = 2'b00;
        axi.m_rlast   = 1'b0;
        axi.m_rid     = 4'd0;
        for (int w = 0; w < BLOCKS; w++) model[w] = '0;
        #2;
        n_cmp++;
        if (fill_busy !== 1'b0 || fill_done !== 1'b0 || fill_err !== 1'b0 ||
            axi.m_arvalid !== 1'b0 || axi.m_rready !== 1'b0 ||
            axi.m_araddr !== '0 || line_out !== '0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b arvalid=%b rready=%b araddr=%h line_nz=%b required all 0",
                     fill_busy, fill_done, fill_err, axi.m_arvalid, axi.m_rready,
                     axi.m_araddr, |line_out);
        end
`ifdef LINE_FILL_LAT_CNT_EN
        n_cmp++;
        if (fill_lat !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_lat: got %0d required 0", fill_lat);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        do_fill(32'h0000_1234, 32'h0000_1200, 0, 100, 64, 63, -1, -1, 1'b0, 66);
    endtask

    task automatic test_stall_gap;
        int d0;
        d0 = done_cnt;
        do_fill(32'hABCD_EF7C, 32'hABCD_EF00, 5, 1000, 64, 63, -1, -1, 1'b1, -1);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_bad++;
            $display("FAIL done_once: pulses=%0d required 1", done_cnt - d0);
        end
    endtask

    task automatic test_errors;
        do_fill(32'h2000_0040, 32'h2000_0000, 0, 5000, 64, 63, 10, -1, 1'b0, 66);
        do_fill(32'h2000_01FF, 32'h2000_0100, 1, 6000, 64, 63, -1, 7, 1'b0, 67);
    endtask

    task automatic test_early_rlast;
        do_fill(32'h4000_0080, 32'h4000_0000, 0, 7000, 32, 31, -1, -1, 1'b0, 34);
    endtask

    task automatic test_missing_rlast;
        do_fill(32'h4000_0300, 32'h4000_0300, 0, 8000, 64, -1, -1, -1, 1'b0, 66);
    endtask

    task automatic test_reset_mid;
        start_fill(32'h3000_00AA);
        addr_phase(32'h3000_0000, 0);
        for (int i = 0; i < 20; i++) begin
            axi.m_rvalid = 1'b1;
            axi.m_rdata  = DW'(9000 + i);
            @(negedge clk);
        end
        axi.m_rdata = DW'(9020);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (axi.m_arvalid !== 1'b0 || axi.m_rready !== 1'b0 ||
            fill_busy !== 1'b0 || line_out !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: arvalid=%b rready=%b busy=%b line_nz=%b required 0 0 0 0",
                     axi.m_arvalid, axi.m_rready, fill_busy, |line_out);
        end
        axi.m_rvalid = 1'b0;
        for (int w = 0; w < BLOCKS; w++) model[w] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_fill(32'h0000_5555, 32'h0000_5500, 0, 200, 64, 63, -1, -1, 1'b0, 66);
    endtask

    task automatic test_back_to_back;
        start_fill(32'h6000_0010);
        addr_phase(32'h6000_0000, 0);
        data_phase(300, 64, 63, 20, -1, 1'b0);
        finish_fill(66);
        fill_req  = 1'b1;
        fill_addr = 32'h7777_7777;
        @(negedge clk);
        n_cmp++;
        if (fill_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL req_in_done: busy=%b required 0", fill_busy);
        end
        acc_cyc = cyc;
        @(negedge clk);
        fill_req = 1'b0;
        n_cmp++;
        if (fill_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL req_after_done: busy=%b required 1", fill_busy);
        end
        addr_phase(32'h7777_7700, 0);
        data_phase(400, 64, 63, -1, -1, 1'b0);
        finish_fill(66);
        @(negedge clk);
    endtask

`ifdef LINE_FILL_LAT_CNT_EN
    task automatic test_lat;
        start_fill(32'h0000_9000);
        addr_phase(32'h0000_9000, 3);
        data_phase(500, 64, 63, -1, -1, 1'b0);
        finish_fill(69);
        n_cmp++;
        if (fill_lat !== 16'd69) begin
            n_bad++;
            $display("FAIL fill_lat: got %0d required 69", fill_lat);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall_gap();
        test_errors();
        test_early_rlast();
        test_missing_rlast();
        test_reset_mid();
        test_back_to_back();
`ifdef LINE_FILL_LAT_CNT_EN
        test_lat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
